// File: rtl/cgra_cfg_pkg.sv
// Shared definitions for the configuration-chain loader.
//
// Contents:
//   cfg_state_t     - loader FSM states (IDLE, FILL, SHIFT, CRC_CHK, DONE)
//   CRC16_POLY      - CRC-16-CCITT polynomial (0x1021)
//   CRC16_INIT      - CRC-16-CCITT initial value (0xFFFF)
//   words_per_chain - number of bitstream words needed to cover a chain
//
// No ports; imported by config_chain_loader and cfg_crc16_serial.

package cgra_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        SHIFT,
        CRC_CHK,
        DONE
    } cfg_state_t;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // Rounds up so a partial final word still counts as a whole word.
    function automatic int words_per_chain(input int len, input int w);
        return (len + w - 1) / w;
    endfunction

endpackage

// File: rtl/cfg_crc16_serial.sv
// Bit-serial CRC-16-CCITT, one message bit per enabled clock.
//
// Ports:
//   i_clk    - clock
//   i_reset  - synchronous active-high reset (loads the init value)
//   i_clear  - synchronous restart of the CRC at the init value
//   i_en     - fold i_bit into the CRC on this edge
//   i_bit    - message bit, supplied in transmission order
//   o_crc    - current CRC register value

module cfg_crc16_serial
    import cgra_cfg_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear,
    input  logic        i_en,
    input  logic        i_bit,
    output logic [15:0] o_crc
);

    logic [15:0] r_crc;
    logic        w_feedback;

    // MSB-first shift register form: the outgoing MSB mixed with the new
    // bit decides whether the polynomial is folded back in.
    assign w_feedback = r_crc[15] ^ i_bit;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_crc <= CRC16_INIT;
        end else if (i_en) begin
            r_crc <= {r_crc[14:0], 1'b0} ^ (w_feedback ? CRC16_POLY : 16'h0000);
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/config_chain_loader.sv
// Streams a configuration bitstream into the fabric's serial config chain,
// one bit per cycle in which o_chain_shift_en is high. Words arrive on a
// ready/valid stream and are shifted LSB-first, in arrival order. A one-word
// prefetch buffer sits behind the shift register so consecutive words shift
// out without a gap whenever the source keeps up.
//
// Optional feature macro: CONFIG_LOADER_CRC_EN
//   defined   - a CRC-16-CCITT over the shifted bits is checked against the
//               low 16 bits of one extra word taken after the data words
//   undefined - no extra word, o_crc_err tied low, no CRC logic
//
// Ports:
//   i_config_clk     - single clock
//   i_config_reset   - synchronous active-high reset
//   i_start          - one-cycle pulse that begins a load (ignored when busy)
//   i_s_data         - bitstream word
//   i_s_valid        - i_s_data valid
//   o_s_ready        - word accepted this cycle when i_s_valid is high
//   o_chain_data     - bit to the first chain cell (holds when not shifting)
//   o_chain_shift_en - chain advances on this edge; gates the fabric clock
//   o_busy           - load in progress
//   o_done           - one-cycle pulse after the final bit has shifted
//   o_crc_err        - CRC mismatch, held until the next start or reset

module config_chain_loader
    import cgra_cfg_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 1024
) (
    input  logic              i_config_clk,
    input  logic              i_config_reset,
    input  logic              i_start,
    input  logic [WORD_W-1:0] i_s_data,
    input  logic              i_s_valid,
    output logic              o_s_ready,
    output logic              o_chain_data,
    output logic              o_chain_shift_en,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_crc_err
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int NW    = words_per_chain(CHAIN_LEN, WORD_W);
`ifdef CONFIG_LOADER_CRC_EN
    localparam int NW_TOTAL = NW + 1;
`else
    localparam int NW_TOTAL = NW;
`endif
    localparam int WC_W = $clog2(NW_TOTAL + 1);
    localparam int SC_W = $clog2(WORD_W + 1);

    cfg_state_t         r_state;
    cfg_state_t         w_next_state;
    logic [WORD_W-1:0]  r_sr;
    logic [SC_W-1:0]    r_sr_cnt;
    logic [WORD_W-1:0]  r_pb;
    logic               r_pb_full;
    logic [WC_W-1:0]    r_words;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic               r_chain_data;
    logic               r_shift_en;

    logic               w_busy;
    logic               w_data_slot;
    logic               w_s_ready;
    logic               w_accept;
    logic               w_bits_left;
    logic               w_shift;
    logic               w_src_sr;
    logic               w_src_pb;
    logic               w_src_in;
    logic [WORD_W-1:0]  w_shift_word;
    logic               w_bit;

    assign w_busy      = (r_state == FILL) || (r_state == SHIFT) || (r_state == CRC_CHK);
    assign w_bits_left = (r_bit_cnt < CNT_W'(CHAIN_LEN));

    // Data words are only taken while the chain still needs them; the CRC
    // word is held off until every data bit has gone out.
`ifdef CONFIG_LOADER_CRC_EN
    assign w_data_slot = ((r_state != CRC_CHK) && (r_words < WC_W'(NW))) || (r_state == CRC_CHK);
`else
    assign w_data_slot = (r_words < WC_W'(NW));
`endif
    assign w_s_ready = w_busy && !r_pb_full && w_data_slot;
    assign w_accept  = i_s_valid && w_s_ready;

    // State register.
    always_ff @(posedge i_config_clk) begin
        if (i_config_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and choice of where the next chain bit comes from.
    // Priority is shift register, then prefetch buffer, then the word being
    // accepted right now, so a refill never costs a cycle.
    always_comb begin
        w_next_state = r_state;
        w_shift      = 1'b0;
        w_src_sr     = 1'b0;
        w_src_pb     = 1'b0;
        w_src_in     = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_next_state = FILL;
                end
            end
            FILL: begin
                if (w_accept) begin
                    w_next_state = SHIFT;
                    w_shift      = 1'b1;
                    w_src_in     = 1'b1;
                end
            end
            SHIFT: begin
                if (!w_bits_left) begin
`ifdef CONFIG_LOADER_CRC_EN
                    w_next_state = CRC_CHK;
`else
                    w_next_state = DONE;
`endif
                end else if (r_sr_cnt != '0) begin
                    w_shift  = 1'b1;
                    w_src_sr = 1'b1;
                end else if (r_pb_full) begin
                    w_shift  = 1'b1;
                    w_src_pb = 1'b1;
                end else if (w_accept) begin
                    w_shift  = 1'b1;
                    w_src_in = 1'b1;
                end
            end
            CRC_CHK: begin
                if (w_accept) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        w_shift_word = i_s_data;
        if (w_src_sr) begin
            w_shift_word = r_sr;
        end else if (w_src_pb) begin
            w_shift_word = r_pb;
        end
    end

    assign w_bit = w_shift_word[0];

    // Datapath. The outgoing bit is registered on the same edge that pops it,
    // so a word accepted in cycle k shows its first bit in cycle k+1. Bits
    // left in the final word past CHAIN_LEN are simply never popped.
    always_ff @(posedge i_config_clk) begin
        if (i_config_reset) begin
            r_sr         <= '0;
            r_sr_cnt     <= '0;
            r_pb         <= '0;
            r_pb_full    <= 1'b0;
            r_words      <= '0;
            r_bit_cnt    <= '0;
            r_chain_data <= 1'b0;
            r_shift_en   <= 1'b0;
        end else begin
            r_shift_en <= w_shift;
            if (r_state == IDLE) begin
                r_sr_cnt  <= '0;
                r_pb_full <= 1'b0;
                r_words   <= '0;
                r_bit_cnt <= '0;
            end
            if (w_shift) begin
                r_chain_data <= w_bit;
                r_bit_cnt    <= r_bit_cnt + 1'b1;
                r_sr         <= w_shift_word >> 1;
                if (w_src_sr) begin
                    r_sr_cnt <= r_sr_cnt - 1'b1;
                end else begin
                    r_sr_cnt <= SC_W'(WORD_W - 1);
                end
            end
            if (w_src_pb) begin
                r_pb_full <= 1'b0;
            end
            if (w_accept) begin
                r_words <= r_words + 1'b1;
                if (!w_src_in && (r_state != CRC_CHK)) begin
                    r_pb      <= i_s_data;
                    r_pb_full <= 1'b1;
                end
            end
        end
    end

`ifdef CONFIG_LOADER_CRC_EN
    logic [15:0] w_crc;
    logic        w_crc_clear;
    logic        r_crc_err;

    assign w_crc_clear = (r_state == IDLE) && i_start;

    cfg_crc16_serial u_crc (
        .i_clk   (i_config_clk),
        .i_reset (i_config_reset),
        .i_clear (w_crc_clear),
        .i_en    (w_shift),
        .i_bit   (w_bit),
        .o_crc   (w_crc)
    );

    // The error flag survives DONE and IDLE so software can read it after
    // the load; only a new start or reset clears it.
    always_ff @(posedge i_config_clk) begin
        if (i_config_reset) begin
            r_crc_err <= 1'b0;
        end else if (w_crc_clear) begin
            r_crc_err <= 1'b0;
        end else if ((r_state == CRC_CHK) && w_accept) begin
            r_crc_err <= (i_s_data[15:0] != w_crc);
        end
    end

    assign o_crc_err = r_crc_err;
`else
    assign o_crc_err = 1'b0;
`endif

    assign o_s_ready        = w_s_ready;
    assign o_chain_data     = r_chain_data;
    assign o_chain_shift_en = r_shift_en;
    assign o_busy           = w_busy;
    assign o_done           = (r_state == DONE);

endmodule

// File: tb/tb_config_chain_loader.sv
// Testbench for config_chain_loader. Two instances share the word stream:
// a 5-bit chain and a 70-bit chain, both with 32-bit words; 'sel' picks
// which one is driven with start and observed. Expected chain bits are
// queued when a word is accepted and popped on every shift-enable cycle.
// Builds with or without CONFIG_LOADER_CRC_EN.

module tb_config_chain_loader;

    localparam int WORD_W = 32;
`ifdef CONFIG_LOADER_CRC_EN
    localparam int CRC_WORDS = 1;
`else
    localparam int CRC_WORDS = 0;
`endif
    localparam logic [31:0] W0 = 32'hA5C3_0F96;
    localparam logic [31:0] W1 = 32'h5A3C_E169;
    localparam logic [31:0] W2 = 32'h7B10_002D;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sValid;
    logic        sel;
    logic [31:0] sData;

    logic ready5, data5, shEn5, busy5, done5, crc5;
    logic ready70, data70, shEn70, busy70, done70, crc70;
    logic obsReady, obsData, obsShiftEn, obsBusy, obsDone, obsCrcErr;

    always #5 clk = ~clk;

    config_chain_loader #(.WORD_W(WORD_W), .CHAIN_LEN(5)) dut5 (
        .i_config_clk     (clk),
        .i_config_reset   (rst),
        .i_start          (start && !sel),
        .i_s_data         (sData),
        .i_s_valid        (sValid),
        .o_s_ready        (ready5),
        .o_chain_data     (data5),
        .o_chain_shift_en (shEn5),
        .o_busy           (busy5),
        .o_done           (done5),
        .o_crc_err        (crc5)
    );

    config_chain_loader #(.WORD_W(WORD_W), .CHAIN_LEN(70)) dut70 (
        .i_config_clk     (clk),
        .i_config_reset   (rst),
        .i_start          (start && sel),
        .i_s_data         (sData),
        .i_s_valid        (sValid),
        .o_s_ready        (ready70),
        .o_chain_data     (data70),
        .o_chain_shift_en (shEn70),
        .o_busy           (busy70),
        .o_done           (done70),
        .o_crc_err        (crc70)
    );

    assign obsReady   = sel ? ready70 : ready5;
    assign obsData    = sel ? data70  : data5;
    assign obsShiftEn = sel ? shEn70  : shEn5;
    assign obsBusy    = sel ? busy70  : busy5;
    assign obsDone    = sel ? done70  : done5;
    assign obsCrcErr  = sel ? crc70   : crc5;

    int          vectorCount = 0;
    int          missCount   = 0;
    bit          expBits[$];
    int          curLen, bitsQueued, shiftCount, acceptCount;
    int          cycle = 0;
    int          firstShift, lastShift, firstAccept, lastAccept, doneCycle;
    logic [15:0] modelCrc;
    logic [4:0]  cellModel;
    logic        prevData;
    bit          prevValid;
    bit          expErr;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] crcStep(input logic [15:0] crc, input logic b);
        logic fb;
        fb = crc[15] ^ b;
        crcStep = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    // Observer: counts accepted words, checks each shifted bit against the
    // queue, checks chain_data holds when not shifting, and models a 5-bit
    // downstream config cell that shifts in at its MSB.
    always @(negedge clk) begin
        cycle++;
        if (rst) begin
            prevValid = 1'b0;
        end else begin
            if (sValid && obsReady) begin
                acceptCount++;
                if (firstAccept < 0) firstAccept = cycle;
                lastAccept = cycle;
            end
            if (obsDone && doneCycle < 0) doneCycle = cycle;
            if (obsShiftEn) begin
                shiftCount++;
                if (firstShift < 0) firstShift = cycle;
                lastShift = cycle;
                cellModel = {obsData, cellModel[4:1]};
                if (expBits.size() == 0) checkOutput("unexpectedShift", 1, 0);
                else checkOutput("chainBit", obsData, expBits.pop_front());
            end else if (prevValid) begin
                checkOutput("holdData", obsData, prevData);
            end
            prevData  = obsData;
            prevValid = 1'b1;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic syncDrive();
        @(posedge clk);
        #1;
    endtask

    task automatic beginLoad(input int len, input bit useSel);
        sel         = useSel;
        curLen      = len;
        bitsQueued  = 0;
        shiftCount  = 0;
        acceptCount = 0;
        firstShift  = -1;
        lastShift   = -1;
        firstAccept = -1;
        lastAccept  = -1;
        doneCycle   = -1;
        expBits.delete();
        modelCrc    = 16'hFFFF;
        cellModel   = '0;
        prevValid   = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        syncDrive();
        start = 1'b0;
    endtask

    // Presents one word (called just after a rising edge) and waits for the
    // handshake; data words queue their in-chain bits for the observer.
    task automatic applyStimulus(input logic [31:0] word, input bit isCrc);
        int guard = 0;
        sData  = word;
        sValid = 1'b1;
        forever begin
            tick();
            if (obsReady) break;
            guard++;
            if (guard > 300) begin
                checkOutput("acceptTimeout", 0, 1);
                sValid = 1'b0;
                return;
            end
        end
        if (!isCrc) begin
            for (int i = 0; i < WORD_W; i++) begin
                if (bitsQueued < curLen) begin
                    expBits.push_back(word[i]);
                    modelCrc = crcStep(modelCrc, word[i]);
                    bitsQueued++;
                end
            end
        end
        syncDrive();
        sValid = 1'b0;
    endtask

    task automatic waitShifts(input int n);
        int guard = 0;
        while (shiftCount < n) begin
            tick();
            guard++;
            if (guard > 300) begin
                checkOutput("shiftTimeout", shiftCount, n);
                return;
            end
        end
    endtask

    task automatic waitDone(input int maxCycles, input bit startAtDone, input bit expCrcErr);
        int guard = 0;
        forever begin
            tick();
            if (obsDone) break;
            guard++;
            if (guard > maxCycles) begin
                checkOutput("doneTimeout", 0, 1);
                syncDrive();
                return;
            end
        end
        if (startAtDone) start = 1'b1;
        checkOutput("busyAtDone", obsBusy, 0);
        checkOutput("shiftCount", shiftCount, curLen);
        checkOutput("bitsLeft", expBits.size(), 0);
        checkOutput("firstShiftLatency", firstShift - firstAccept, 1);
`ifdef CONFIG_LOADER_CRC_EN
        checkOutput("doneAfterCrcWord", doneCycle - lastAccept, 1);
`else
        checkOutput("doneAfterLastShift", doneCycle - lastShift, 1);
`endif
        checkOutput("crcErr", obsCrcErr, expCrcErr);
        syncDrive();
        start = 1'b0;
        tick();
        checkOutput("donePulse", obsDone, 0);
        checkOutput("idleBusy", obsBusy, 0);
        if (startAtDone) checkOutput("startAtDoneIgnored", obsReady, 0);
        syncDrive();
    endtask

    task automatic sendCrcWord(input logic [15:0] flip);
`ifdef CONFIG_LOADER_CRC_EN
        applyStimulus({16'h0000, modelCrc ^ flip}, 1'b1);
`else
        if (flip != 16'h0000) $display("[TB] no CRC word in this build");
`endif
    endtask

    task automatic loadFull70(input bit holdValid);
        beginLoad(70, 1'b1);
        pulseStart();
        applyStimulus(W0, 1'b0);
        applyStimulus(W1, 1'b0);
        applyStimulus(W2, 1'b0);
        sendCrcWord(16'h0000);
        if (holdValid) begin
            sValid = 1'b1;
            sData  = 32'hCAFE_F00D;
        end
        waitDone(300, 1'b0, 1'b0);
        sValid = 1'b0;
        checkOutput("wordsAccepted70", acceptCount, 3 + CRC_WORDS);
        checkOutput("noBubble", lastShift - firstShift + 1, 70);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; sValid = 1'b0; sData = '0;
        beginLoad(5, 1'b0);
        repeat (2) @(posedge clk);
        tick();
        checkOutput("rstReady", obsReady, 0);
        checkOutput("rstData", obsData, 0);
        checkOutput("rstShiftEn", obsShiftEn, 0);
        checkOutput("rstBusy", obsBusy, 0);
        checkOutput("rstDone", obsDone, 0);
        checkOutput("rstCrcErr", obsCrcErr, 0);
        checkOutput("rstBusy70", busy70, 0);
        syncDrive();
        rst = 1'b0;

        // Valid words while idle must never be taken.
        sValid = 1'b1;
        sData  = 32'hFFFF_FFFF;
        repeat (3) begin
            tick();
            checkOutput("idleReady", obsReady, 0);
        end
        checkOutput("idleAccepts", acceptCount, 0);
        syncDrive();
        sValid = 1'b0;

        // 5-bit chain: bits 1,1,0,0,1 and the cell ends at 5'b10011.
        beginLoad(5, 1'b0);
        pulseStart();
        tick();
        checkOutput("readyAfterStart", obsReady, 1);
        checkOutput("busyAfterStart", obsBusy, 1);
        syncDrive();
        applyStimulus(32'hFFFF_FFF3, 1'b0);
        sendCrcWord(16'h0000);
        waitDone(100, 1'b0, 1'b0);
        checkOutput("cellContents", cellModel, 5'b10011);
        checkOutput("wordsAccepted5", acceptCount, 1 + CRC_WORDS);

        // Start coincident with done is dropped; bad CRC word flags an error.
        beginLoad(5, 1'b0);
        pulseStart();
        applyStimulus(32'h0000_0013, 1'b0);
        expErr = (CRC_WORDS != 0);
        sendCrcWord(16'h0001);
        waitDone(100, 1'b1, expErr);
        repeat (3) tick();
        checkOutput("crcErrHeld", obsCrcErr, expErr);
        checkOutput("stillIdle", obsBusy, 0);
        syncDrive();
        beginLoad(5, 1'b0);
        pulseStart();
        tick();
        checkOutput("crcErrClearedOnStart", obsCrcErr, 0);
        syncDrive();
        applyStimulus(32'h0000_0013, 1'b0);
        sendCrcWord(16'h0000);
        waitDone(100, 1'b0, 1'b0);
        checkOutput("cellContents2", cellModel, 5'b10011);

        // 70-bit chain with valid held high: three words, no bubble, no fourth.
        loadFull70(1'b1);

        // Source stalls after word 1; a stray start mid-load is ignored.
        beginLoad(70, 1'b1);
        pulseStart();
        applyStimulus(W0, 1'b0);
        applyStimulus(W1, 1'b0);
        waitShifts(40);
        syncDrive();
        pulseStart();
        waitShifts(64);
        repeat (4) tick();
        syncDrive();
        applyStimulus(W2, 1'b0);
        sendCrcWord(16'h0000);
        waitDone(300, 1'b0, 1'b0);
        checkOutput("stallSeen", (lastShift - firstShift + 1 - 70) >= 4, 1);
        checkOutput("wordsAcceptedStall", acceptCount, 3 + CRC_WORDS);

        // Reset after 20 bits, then a clean full reload.
        beginLoad(70, 1'b1);
        pulseStart();
        applyStimulus(W0, 1'b0);
        waitShifts(20);
        syncDrive();
        rst = 1'b1;
        @(posedge clk);
        tick();
        checkOutput("midRstReady", obsReady, 0);
        checkOutput("midRstData", obsData, 0);
        checkOutput("midRstShiftEn", obsShiftEn, 0);
        checkOutput("midRstBusy", obsBusy, 0);
        checkOutput("midRstDone", obsDone, 0);
        checkOutput("midRstCrcErr", obsCrcErr, 0);
        syncDrive();
        rst = 1'b0;
        expBits.delete();
        loadFull70(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
